// File: rtl/ks_control_unit.sv
// K&S processor control unit: a Moore FSM that sequences fetch, decode and
// execute, driving every datapath enable/select and the RAM write strobe.

package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

endpackage

module ks_control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [3:0]              fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_LOAD_1   = 4'd2,
    S_STORE_1  = 4'd3,
    S_STORE_2  = 4'd4,
    S_MOVE_1   = 4'd5,
    S_MOVE_2   = 4'd6,
    S_ALU_1    = 4'd7,
    S_ALU_2    = 4'd8,
    S_BRANCH_1 = 4'd9,
    S_HALT     = 4'd15
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t FETCH_CTRL = '{
    branch: 1'b0, pc_enable: 1'b1, ir_enable: 1'b1, addr_sel: 1'b0,
    c_sel: 1'b0, operation: OP_ADD, write_reg_enable: 1'b0,
    flags_reg_enable: 1'b0, ram_write_enable: 1'b0, halt: 1'b0
  };

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  // The carry flag is visible to the controller but no branch depends on it.
  logic unused_flags;
  assign unused_flags = unsigned_overflow;

  function automatic alu_op_t alu_op_for(decoded_instruction_type instr);
    case (instr)
      I_SUB:   return OP_SUB;
      I_AND:   return OP_AND;
      I_OR:    return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

  // Output vector of a state; evaluated on the state being entered so the
  // outputs come straight from flops yet stay aligned with fsm_state.
  function automatic ctrl_t ctrl_for(state_t s, decoded_instruction_type instr);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    c = FETCH_CTRL;
      S_LOAD_1: begin
        c.addr_sel         = 1'b1;
        c.c_sel            = 1'b1;
        c.write_reg_enable = 1'b1;
      end
      S_STORE_2: begin
        c.addr_sel         = 1'b1;
        c.ram_write_enable = 1'b1;
      end
      S_MOVE_2: begin
        c.operation        = OP_OR;
        c.write_reg_enable = 1'b1;
      end
      S_ALU_1:    c.operation = alu_op_for(instr);
      S_ALU_2: begin
        c.operation        = alu_op_for(instr);
        c.write_reg_enable = 1'b1;
        c.flags_reg_enable = 1'b1;
      end
      S_BRANCH_1: begin
        c.addr_sel  = 1'b1;
        c.branch    = 1'b1;
        c.pc_enable = 1'b1;
      end
      S_HALT:     c.halt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t cond_branch(logic take);
    return take ? S_BRANCH_1 : S_FETCH;
  endfunction

  always_comb begin
    // NOTE: every path of a combinational block must assign each target;
    // the up-front default keeps synthesis from inferring a latch.
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:   next_state = S_LOAD_1;
          I_STORE:  next_state = S_STORE_1;
          I_MOVE:   next_state = S_MOVE_1;
          I_ADD, I_SUB, I_AND, I_OR: next_state = S_ALU_1;
          I_BRANCH: next_state = S_BRANCH_1;
          I_BZERO:  next_state = cond_branch(zero_op);
          I_BNZERO: next_state = cond_branch(!zero_op);
          I_BNEG:   next_state = cond_branch(neg_op);
          I_BNNEG:  next_state = cond_branch(!neg_op);
          I_BOV:    next_state = cond_branch(signed_overflow);
          I_BNOV:   next_state = cond_branch(!signed_overflow);
          I_HALT:   next_state = S_HALT;
          default:  next_state = S_FETCH;
        endcase
      end
      S_LOAD_1:   next_state = S_FETCH;
      S_STORE_1:  next_state = S_STORE_2;
      S_STORE_2:  next_state = S_FETCH;
      S_MOVE_1:   next_state = S_MOVE_2;
      S_MOVE_2:   next_state = S_FETCH;
      S_ALU_1:    next_state = S_ALU_2;
      S_ALU_2:    next_state = S_FETCH;
      S_BRANCH_1: next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  // Asynchronous reset forces FETCH outputs at once, so no write strobe
  // survives a reset asserted mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= S_FETCH;
      ctrl  <= FETCH_CTRL;
    end else begin
      state <= next_state;
      ctrl  <= ctrl_for(next_state, decoded_instruction);
    end
  end

  assign branch           = ctrl.branch;
  assign pc_enable        = ctrl.pc_enable;
  assign ir_enable        = ctrl.ir_enable;
  assign addr_sel         = ctrl.addr_sel;
  assign c_sel            = ctrl.c_sel;
  assign operation        = ctrl.operation;
  assign write_reg_enable = ctrl.write_reg_enable;
  assign flags_reg_enable = ctrl.flags_reg_enable;
  assign ram_write_enable = ctrl.ram_write_enable;
  assign halt             = ctrl.halt;
  assign fsm_state        = state;

  a_write_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_write_enable && write_reg_enable));
  a_ir_only_in_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    ir_enable == (state == S_FETCH));

endmodule

// File: tb/tb_ks_control_unit.sv
// Scoreboard bench for ks_control_unit: the driver queues the expected
// state/control vector of each cycle, a negedge monitor pops and compares.

module tb_ks_control_unit;
  import k_and_s_pkg::*;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_LOAD1  = 4'd2;
  localparam logic [3:0] ST_STORE1 = 4'd3;
  localparam logic [3:0] ST_STORE2 = 4'd4;
  localparam logic [3:0] ST_MOVE1  = 4'd5;
  localparam logic [3:0] ST_MOVE2  = 4'd6;
  localparam logic [3:0] ST_ALU1   = 4'd7;
  localparam logic [3:0] ST_ALU2   = 4'd8;
  localparam logic [3:0] ST_BR1    = 4'd9;
  localparam logic [3:0] ST_HALT   = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  decoded_instruction_type instr = I_NOP;
  logic zero_op = 1'b0;
  logic neg_op = 1'b0;
  logic unsigned_overflow = 1'b0;
  logic signed_overflow = 1'b0;

  logic       branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic       write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [3:0] fsm_state;

  ks_control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (instr),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .fsm_state           (fsm_state)
  );

  always #5 clk = ~clk;

  // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation, wre, fre, rwe, halt}
  logic [10:0] dut_ctrl;
  assign dut_ctrl = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                     write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [10:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Expected control vector of each state, written out from the state table.
  function automatic logic [10:0] exp_ctrl(input logic [3:0] st, input logic [1:0] op);
    case (st)
      ST_FETCH:  return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      ST_LOAD1:  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
      ST_STORE2: return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
      ST_MOVE2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
      ST_ALU1:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op,    1'b0, 1'b0, 1'b0, 1'b0};
      ST_ALU2:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op,    1'b1, 1'b1, 1'b0, 1'b0};
      ST_BR1:    return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      ST_HALT:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
      default:   return 11'd0;
    endcase
  endfunction

  task automatic expect_cycle(input string tag, input logic [3:0] st,
                              input logic [1:0] op = 2'b00);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.ctrl = exp_ctrl(st, op);
    exp_q.push_back(e);
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(input string tag, input logic [3:0] st,
                      input logic [1:0] op = 2'b00);
    expect_cycle(tag, st, op);
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic z, input logic n, input logic v);
    zero_op = z;
    neg_op = n;
    signed_overflow = v;
  endtask

  task automatic run_alu(input string tag, input decoded_instruction_type i,
                         input logic [1:0] op);
    instr = i;
    step({tag, "_fetch"}, ST_FETCH);
    step({tag, "_decode"}, ST_DECODE);
    step({tag, "_alu1"}, ST_ALU1, op);
    step({tag, "_alu2"}, ST_ALU2, op);
  endtask

  task automatic run_branch(input string tag, input decoded_instruction_type i,
                            input logic z, input logic n, input logic v,
                            input logic taken);
    instr = i;
    set_flags(z, n, v);
    step({tag, "_fetch"}, ST_FETCH);
    step({tag, "_decode"}, ST_DECODE);
    if (taken) step({tag, "_br1"}, ST_BR1);
  endtask

  // Monitor: one comparison pair per cycle that the driver has scheduled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_state"}, 32'(fsm_state), 32'(e.st));
        check({e.tag, "_ctrl"}, 32'(dut_ctrl), 32'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    step("rst_a", ST_FETCH);
    step("rst_b", ST_FETCH);
    rst_n = 1'b1;

    // LOAD R1,[20]: 0,1,2 then back to FETCH
    instr = I_LOAD;
    step("load_fetch", ST_FETCH);
    step("load_decode", ST_DECODE);
    step("load_1", ST_LOAD1);

    // ADD R2=R1+R1 with R1=0x7FFF yields 0xFFFE: negative, signed overflow
    run_alu("add", I_ADD, 2'b00);
    run_branch("bov_taken", I_BOV, 1'b0, 1'b1, 1'b1, 1'b1);
    run_branch("bov_not", I_BOV, 1'b0, 1'b1, 1'b0, 1'b0);

    // STORE R2,[25]
    instr = I_STORE;
    step("store_fetch", ST_FETCH);
    step("store_decode", ST_DECODE);
    step("store_1", ST_STORE1);
    step("store_2", ST_STORE2);

    instr = I_MOVE;
    step("move_fetch", ST_FETCH);
    step("move_decode", ST_DECODE);
    step("move_1", ST_MOVE1);
    step("move_2", ST_MOVE2);

    run_alu("sub", I_SUB, 2'b01);
    run_alu("and", I_AND, 2'b10);
    run_alu("or", I_OR, 2'b11);

    run_branch("bz_taken", I_BZERO, 1'b1, 1'b0, 1'b0, 1'b1);
    run_branch("bz_not", I_BZERO, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("bnz_taken", I_BNZERO, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch("bnz_not", I_BNZERO, 1'b1, 1'b0, 1'b0, 1'b0);
    run_branch("bneg_taken", I_BNEG, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch("bneg_not", I_BNEG, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("bnneg_not", I_BNNEG, 1'b0, 1'b1, 1'b0, 1'b0);
    run_branch("bnneg_taken", I_BNNEG, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch("bnov_taken", I_BNOV, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch("bnov_not", I_BNOV, 1'b0, 1'b0, 1'b1, 1'b0);
    run_branch("jump", I_BRANCH, 1'b0, 1'b0, 1'b0, 1'b1);
    // Carry alone must not make BOV branch
    unsigned_overflow = 1'b1;
    run_branch("bov_carry", I_BOV, 1'b0, 1'b0, 1'b0, 1'b0);
    unsigned_overflow = 1'b0;
    run_branch("nop", I_NOP, 1'b1, 1'b1, 1'b1, 1'b0);
    run_branch("undef", decoded_instruction_type'(5'd20), 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset dropped inside ALU_1, after the monitor has seen that cycle
    instr = I_ADD;
    step("rstmid_fetch", ST_FETCH);
    step("rstmid_decode", ST_DECODE);
    expect_cycle("rstmid_alu1", ST_ALU1, 2'b00);
    #6;
    rst_n = 1'b0;
    #1;
    check("rstmid_async_state", 32'(fsm_state), 32'(ST_FETCH));
    check("rstmid_async_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(ST_FETCH, 2'b00)));
    @(posedge clk);
    #1;
    check("rstmid_no_reg_write", 32'({write_reg_enable, flags_reg_enable}), 32'd0);
    step("rstmid_hold", ST_FETCH);
    rst_n = 1'b1;

    // HALT parks for 50 cycles even once the decode input changes
    instr = I_HALT;
    step("halt_fetch", ST_FETCH);
    step("halt_decode", ST_DECODE);
    step("halt_0", ST_HALT);
    instr = I_NOP;
    for (int i = 1; i < 50; i++) step("halt_n", ST_HALT);
    rst_n = 1'b0;
    #1;
    check("halt_rst_state", 32'(fsm_state), 32'(ST_FETCH));
    @(posedge clk);
    #1;
    step("halt_rst_hold", ST_FETCH);
    rst_n = 1'b1;
    step("restart_fetch", ST_FETCH);
    step("restart_decode", ST_DECODE);
    step("restart_next", ST_FETCH);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
